cntry_car_detector: RTL and testbench
=====================================

Name: cntry_car_detector

Overview:
- Vehicle-presence front end that produces the car_on_cntry request (X) consumed by the traffic signal controller (sig_control).
- Conditions the raw country-road loop detector: synchronise, debounce, count arrivals.
- Watches the returned country signal and retires queued cars while the country road shows GREEN.
- Holds car_on_cntry high until the queue drains.

Parameters:
- DEBOUNCE_CYCLES, 3, consecutive synchronised samples at the new level required before the filtered level flips (legal range 1..15).
- CNT_W, 4, width of the queue counter; saturates at 2^CNT_W-1.
- DEPART_CYCLES, 2, continuous GREEN cycles per departing car (legal range 1..255).
- STUCK_CYCLES, 64, filtered-high duration that flags a stuck loop (used only with the optional feature).

Ports:
- clock  in  1  system clock; all state on the rising edge.
- clear_n  in  1  asynchronous active-low reset.
- loop_raw  in  1  raw loop detector; asynchronous to clock; may bounce.
- cntry_sig  in  2  country signal from the controller: 2'd0 RED, 2'd1 YELLOW, 2'd2 GREEN, 2'd3 illegal.
- car_on_cntry  out  1  request to the controller (X).
- queue_count  out  CNT_W  cars currently waiting.
- det_state  out  2  FSM state: 0 IDLE, 1 WAITING, 2 SERVING.
- overflow  out  1  sticky; an arrival was seen while the queue was full.
- stuck_fault  out  1  loop-stuck flag; constant 0 unless STUCK_DETECT_EN is defined.

Behaviour:
- Reset: clear_n low asynchronously clears every register.
  - All outputs read 0 and det_state reads IDLE while clear_n is low.
  - Reset asserted mid-operation drops any queued cars; no partial state survives.
- Synchroniser: two flops on loop_raw, giving s2.
- Debounce counter:
  - Counts edges where s2 differs from the filtered level filt.
  - Clears on any edge where s2 equals filt.
  - filt toggles on the DEBOUNCE_CYCLES-th consecutive differing edge.
  - Pulses shorter than DEBOUNCE_CYCLES synchronised samples are ignored.
- Arrival: arrive = filt & ~filt_d, where filt_d is filt registered one cycle. One arrival per filtered rising edge; a falling edge is not an event.
- Departure timer:
  - Counts while cntry_sig==GREEN and queue_count!=0.
  - Cleared whenever cntry_sig!=GREEN or queue_count==0.
  - On reaching DEPART_CYCLES-1 it issues depart for one cycle and restarts from 0.
  - YELLOW, RED and illegal 2'd3 are all treated as not-GREEN.
- Queue update, registered:
  - arrive only: +1. At max the count holds and overflow sets.
  - depart only: -1. depart is never issued at 0.
  - arrive and depart in the same cycle: count unchanged.
- car_on_cntry = (queue_count != 0), decoded from the registered count.
- Latency: with edge 1 as the first edge sampling loop_raw high, car_on_cntry rises after edge DEBOUNCE_CYCLES+3 (edge 6 at default parameters).
- FSM, registered and evaluated on next-state count:
  - IDLE -> WAITING when count becomes nonzero and cntry_sig!=GREEN.
  - IDLE or WAITING -> SERVING when cntry_sig==GREEN and count nonzero.
  - SERVING -> WAITING when cntry_sig leaves GREEN with count nonzero.
  - Any state -> IDLE when count becomes 0.
- overflow stays set until reset.

Optional Feature:
- Macro: STUCK_DETECT_EN.
- Defined:
  - A counter runs while filt is high and clears when filt is low.
  - When it reaches STUCK_CYCLES, stuck_fault asserts and car_on_cntry is forced to 1 (fail-safe: serve the country road).
  - Arrivals are suppressed while stuck_fault is set.
  - stuck_fault clears on the first cycle filt returns low.
- Not defined: no stuck counter; stuck_fault is tied to 0; behaviour is exactly as above.

Test Plan:
- Reset: clock period 10 ns, clear_n low for 5 negedges -> all outputs 0 and det_state=0 throughout; clear_n=1 with loop_raw=0 and cntry_sig=0 -> outputs stay 0.
- Single car: loop_raw high for 8 cycles, cntry_sig=RED -> car_on_cntry and queue_count=1 appear after edge 6; det_state=1; they hold indefinitely.
- Glitch rejection: loop_raw high for 2 cycles, repeated 5 times with 4 low cycles between -> queue_count stays 0 and car_on_cntry stays 0.
- Serve and drain:
  - Setup: 3 debounced cars queued, then cntry_sig=GREEN held.
  - Response: det_state=2; queue_count goes 3->2->1->0 every 2 cycles; car_on_cntry falls the cycle count hits 0; det_state=0.
- Simultaneous and saturation:
  - Arrival coinciding with a depart -> count unchanged.
  - 17 arrivals with CNT_W=4 -> count saturates at 15 and overflow=1.
  - clear_n pulsed low mid-queue -> immediate all-zero outputs.
- STUCK_DETECT_EN defined: loop_raw held high for 80 cycles -> stuck_fault=1 at the 64th filtered-high cycle and car_on_cntry=1; loop_raw low -> stuck_fault clears once filt drops.

Source files
------------

// File: rtl/cntry_car_detector.sv
// Country-road vehicle detector: synchronises, debounces and queues loop arrivals,
// retires them on GREEN, and drives car_on_cntry. Optional stuck-loop monitor: STUCK_DETECT_EN.
module cntry_car_detector #(
    parameter int unsigned DEBOUNCE_CYCLES = 3,
    parameter int unsigned CNT_W           = 4,
    parameter int unsigned DEPART_CYCLES   = 2,
    parameter int unsigned STUCK_CYCLES    = 64
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             loop_raw,
    input  logic [1:0]       cntry_sig,
    output logic             car_on_cntry,
    output logic [CNT_W-1:0] queue_count,
    output logic [1:0]       det_state,
    output logic             overflow,
    output logic             stuck_fault
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAITING = 2'd1,
        SERVING = 2'd2
    } state_e;

    localparam logic [1:0]       SIG_GREEN = 2'd2;
    localparam logic [3:0]       DB_LAST   = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]       DEP_LAST  = 8'(DEPART_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             s1_q, s2_q;
    logic             filt_q, filt_d, filt_dly_q;
    logic [3:0]       db_cnt_q, db_cnt_d;
    logic [7:0]       dep_cnt_q, dep_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    state_e           state_q, state_d;
    logic             green, arrive, depart, arrive_ok, queue_busy;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            filt_q     <= 1'b0;
            filt_dly_q <= 1'b0;
            db_cnt_q   <= '0;
            dep_cnt_q  <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            s1_q       <= loop_raw;
            s2_q       <= s1_q;
            filt_q     <= filt_d;
            filt_dly_q <= filt_q;
            db_cnt_q   <= db_cnt_d;
            dep_cnt_q  <= dep_cnt_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    // Filtered level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        filt_d   = filt_q;
        db_cnt_d = '0;
        if (s2_q != filt_q) begin
            if (db_cnt_q == DB_LAST) begin
                filt_d = ~filt_q;
            end else begin
                db_cnt_d = db_cnt_q + 4'd1;
            end
        end
    end

    assign green      = (cntry_sig == SIG_GREEN);
    assign queue_busy = (cnt_q != '0);
    assign arrive     = filt_q & ~filt_dly_q & arrive_ok;
    assign depart     = green & queue_busy & (dep_cnt_q == DEP_LAST);

    always_comb begin
        dep_cnt_d = '0;
        if (green && queue_busy && !depart) begin
            dep_cnt_d = dep_cnt_q + 8'd1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (arrive && !depart) begin
            if (cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (depart && !arrive) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Transitions look at the count being written this cycle, not the current one.
    always_comb begin
        state_d = state_q;
        if (cnt_d == '0) begin
            state_d = IDLE;
        end else if (green) begin
            state_d = SERVING;
        end else begin
            state_d = WAITING;
        end
    end

    always_comb begin
        det_state = state_q;
    end

    assign queue_count = cnt_q;
    assign overflow    = ovf_q;

`ifdef STUCK_DETECT_EN
    localparam int unsigned       SC_W     = $clog2(STUCK_CYCLES + 1);
    localparam logic [SC_W-1:0]   SC_LIMIT = SC_W'(STUCK_CYCLES);

    logic [SC_W-1:0] sc_cnt_q, sc_cnt_d;
    logic            stuck_q, stuck_d;

    always_comb begin
        sc_cnt_d = '0;
        stuck_d  = 1'b0;
        if (filt_q) begin
            sc_cnt_d = (sc_cnt_q == SC_LIMIT) ? sc_cnt_q : sc_cnt_q + 1'b1;
            stuck_d  = (sc_cnt_d == SC_LIMIT);
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            sc_cnt_q <= '0;
            stuck_q  <= 1'b0;
        end else begin
            sc_cnt_q <= sc_cnt_d;
            stuck_q  <= stuck_d;
        end
    end

    // Gated by filt so the flag drops in the same cycle the loop releases.
    assign stuck_fault  = stuck_q & filt_q;
    assign arrive_ok    = ~stuck_fault;
    assign car_on_cntry = queue_busy | stuck_fault;
`else
    assign stuck_fault  = 1'b0;
    assign arrive_ok    = 1'b1;
    assign car_on_cntry = queue_busy;
`endif

endmodule

// File: tb/tb_cntry_car_detector.sv
// Directed self-checking bench for cntry_car_detector (default build, default parameters).
module tb_cntry_car_detector;

    logic       clock = 1'b0;
    logic       clear_n;
    logic       loop_raw;
    logic [1:0] cntry_sig;
    logic       car_on_cntry;
    logic [3:0] queue_count;
    logic [1:0] det_state;
    logic       overflow;
    logic       stuck_fault;

    int checks   = 0;
    int failures = 0;

    cntry_car_detector #(
        .DEBOUNCE_CYCLES(3),
        .CNT_W          (4),
        .DEPART_CYCLES  (2),
        .STUCK_CYCLES   (64)
    ) dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .loop_raw    (loop_raw),
        .cntry_sig   (cntry_sig),
        .car_on_cntry(car_on_cntry),
        .queue_count (queue_count),
        .det_state   (det_state),
        .overflow    (overflow),
        .stuck_fault (stuck_fault)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic car, input logic [3:0] cnt,
                             input logic [1:0] st, input logic ovf);
        check({tag, ".car"},   32'(car_on_cntry), 32'(car));
        check({tag, ".count"}, 32'(queue_count),  32'(cnt));
        check({tag, ".state"}, 32'(det_state),    32'(st));
        check({tag, ".ovf"},   32'(overflow),     32'(ovf));
        check({tag, ".stuck"}, 32'(stuck_fault),  32'd0);
    endtask

    task automatic add_car();
        loop_raw = 1'b1;
        repeat (8) @(negedge clock);
        loop_raw = 1'b0;
        repeat (8) @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] sim_cnt [1:10];
        logic [3:0] drain_cnt [1:6];

        clear_n   = 1'b0;
        loop_raw  = 1'b0;
        cntry_sig = 2'd0;

        repeat (5) begin
            @(negedge clock);
            check_out("reset", 1'b0, 4'd0, 2'd0, 1'b0);
        end
        clear_n = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check_out("post_reset", 1'b0, 4'd0, 2'd0, 1'b0);
        end

        // Two-sample pulses never reach the three-sample debounce threshold.
        repeat (5) begin
            loop_raw = 1'b1;
            repeat (2) begin
                @(negedge clock);
                check_out("glitch_hi", 1'b0, 4'd0, 2'd0, 1'b0);
            end
            loop_raw = 1'b0;
            repeat (4) begin
                @(negedge clock);
                check_out("glitch_lo", 1'b0, 4'd0, 2'd0, 1'b0);
            end
        end

        // Single car under RED: request appears after edge 6.
        loop_raw = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (k >= 6) check_out($sformatf("single_e%0d", k), 1'b1, 4'd1, 2'd1, 1'b0);
            else        check_out($sformatf("single_e%0d", k), 1'b0, 4'd0, 2'd0, 1'b0);
        end
        loop_raw = 1'b0;
        repeat (20) @(negedge clock);
        check_out("single_hold", 1'b1, 4'd1, 2'd1, 1'b0);

        add_car();
        add_car();
        check_out("three_queued", 1'b1, 4'd3, 2'd1, 1'b0);

        // GREEN drains one car every two cycles.
        drain_cnt = '{4'd3, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0};
        cntry_sig = 2'd2;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (k < 6) check_out($sformatf("drain_e%0d", k), 1'b1, drain_cnt[k], 2'd2, 1'b0);
            else       check_out($sformatf("drain_e%0d", k), 1'b0, drain_cnt[k], 2'd0, 1'b0);
        end

        cntry_sig = 2'd0;
        add_car();
        add_car();
        check_out("two_queued", 1'b1, 4'd2, 2'd1, 1'b0);

        // GREEN from loop edge 5 puts the first depart on loop edge 6, same as the arrival.
        sim_cnt = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0};
        loop_raw = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            check($sformatf("simul_e%0d.count", k), 32'(queue_count), 32'(sim_cnt[k]));
            if (k == 5) check("simul_e5.state", 32'(det_state), 32'd2);
            if (k == 4) cntry_sig = 2'd2;
            if (k == 8) loop_raw = 1'b0;
        end
        check_out("simul_done", 1'b0, 4'd0, 2'd0, 1'b0);
        cntry_sig = 2'd0;
        repeat (8) @(negedge clock);
        check_out("simul_idle", 1'b0, 4'd0, 2'd0, 1'b0);

        repeat (15) add_car();
        check_out("full_15", 1'b1, 4'd15, 2'd1, 1'b0);
        repeat (2) add_car();
        check_out("saturated", 1'b1, 4'd15, 2'd1, 1'b1);

        // Asynchronous clear between clock edges.
        #2 clear_n = 1'b0;
        #1 check_out("async_clear", 1'b0, 4'd0, 2'd0, 1'b0);
        @(negedge clock);
        check_out("clear_held", 1'b0, 4'd0, 2'd0, 1'b0);
        clear_n = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check_out("after_clear", 1'b0, 4'd0, 2'd0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
